lut_sweep_eval: RTL
===================

Name: lut_sweep_eval

Overview:
- Parametrised successor to the fixed 4-input boolean evaluator.
- Implements an N_IN-input boolean function as a serially-programmable truth table.
- Registers the function output for a live input vector.
- Provides a self-test sweep mode that walks all 2^N_IN input vectors and counts how many evaluate true.
- Sits alongside the combinational exercise blocks as the reusable, bench-checkable version.

Parameters:
- N_IN, 4, number of function inputs. Legal range 1..8. Truth-table size TT = 2^N_IN is a derived localparam.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  serial truth-table bit is present.
- cfg_bit  in  1  serial truth-table data.
- cfg_ready  out  1  block accepts cfg bits (high only in IDLE).
- in_vec  in  N_IN  live input vector. Bit N_IN-1 is input "a" (MSB).
- out_e  out  1  registered function value for in_vec.
- sweep_start  in  1  request exhaustive sweep.
- busy  out  1  sweep in progress.
- sweep_vec  out  N_IN  vector currently being evaluated in the sweep.
- done  out  1  one-cycle pulse when the sweep completes.
- ones_count  out  N_IN+1  number of true entries found by the last sweep.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: tt=0, state=IDLE, out_e=0, cfg_ready=0 during the reset cycle then 1, busy=0, done=0, sweep_vec=0, ones_count=0.
- Truth table storage: tt[TT-1:0].
- Load (IDLE only):
  - Each cycle with cfg_valid=1, tt <= {cfg_bit, tt[TT-1:1]}.
  - After TT accepted bits, the first bit sent sits in tt[0] and the last in tt[TT-1].
  - There is no load counter: a partial or over-length load simply shifts.
  - cfg_valid outside IDLE is ignored; tt is unchanged.
- Live evaluation:
  - out_e <= tt[in_vec] every cycle in every state, using tt as it stood at the start of that cycle.
  - Latency is 1 cycle.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start=1. On that edge: ones_count<=0, sweep_vec<=0, busy<=1.
  - If sweep_start and cfg_valid are both 1 in IDLE, the sweep wins and the cfg bit is dropped.
  - SWEEP:
    - Each cycle: ones_count <= ones_count + tt[sweep_vec], and sweep_vec increments.
    - When sweep_vec == TT-1: accumulate that entry, go to DONE, busy<=0, sweep_vec holds at TT-1.
  - DONE: done=1 for exactly this cycle, then unconditionally back to IDLE.
  - sweep_start is ignored in SWEEP and DONE; no queuing.
- Sweep timing:
  - sweep_start sampled at edge k.
  - busy is high for cycles k+1 .. k+TT.
  - done is high in cycle k+TT+1.
- ones_count:
  - Width is N_IN+1, so TT (all ones) is representable with no wrap.
  - Holds its final value from DONE until the next sweep start.
- sweep_vec holds its last value in IDLE.
- Reset mid-load or mid-sweep: immediate return to reset values. tt is cleared, and no done pulse is produced.

Decomposition:
- Shared package lut_pkg:
  - State enum {IDLE=2'd0, SWEEP=2'd1, DONE=2'd2}.
  - Function tt_size(n) returning 2^n.
  - Constant MAX_N_IN=8.
- Optional sub-module tt_shift_reg holds tt, the shift-load logic and the read mux. The FSM and counters stay in lut_sweep_eval.

Test Plan:
- Table load and live evaluation (N_IN=4):
  - Stimulus: shift 16 bits of table 0x8001, LSB first, then drive in_vec 0000, 0001, 1111, 1101 for one cycle each.
  - Required: out_e is 1, 0, 1, 0, each one cycle after its vector.
- Sweep of 0x8001:
  - Stimulus: sweep_start pulse at cycle k.
  - Required: busy high for cycles k+1..k+16, done pulse at k+17, ones_count=2, sweep_vec=15 after completion.
- Width boundary:
  - Stimulus: load 0xFFFF, then sweep.
  - Required: ones_count=16 (5'b10000), no wrap. Then load 0x0000 and sweep: ones_count=0.
- Ignored inputs during a sweep:
  - Stimulus: cfg_valid=1 with cfg_bit=1, and sweep_start=1, both held throughout a sweep.
  - Required: tt unchanged, cfg_ready=0, a single done pulse, no re-trigger until IDLE.
  - Also: sweep_start and cfg_valid together in IDLE -> the sweep starts and tt does not shift.
- Reset mid-sweep:
  - Stimulus: rst_n=0 at sweep cycle 7.
  - Required: next cycle busy=0, done never pulses, ones_count=0, tt=0, out_e=0.
- N_IN=2 instance:
  - Stimulus: load 4'b0110 (XOR), then sweep.
  - Required: in_vec 01 -> out_e=1, in_vec 11 -> out_e=0, ones_count=2, done at k+5.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types and helpers for the serially-programmed truth-table evaluator.
package lut_pkg;

    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int tt_size(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/lut_sweep_eval_tt_shift_reg.sv
// Truth-table storage: serial shift-in at the top, two independent read ports.
module tt_shift_reg
    import lut_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            shift_en,
    input  logic            shift_bit,
    input  logic [N_IN-1:0] rd_addr_a,
    input  logic [N_IN-1:0] rd_addr_b,
    output logic            rd_bit_a,
    output logic            rd_bit_b
);

    localparam int TT = tt_size(N_IN);

    logic [TT-1:0] r_tt;
    logic [TT-1:0] w_tt_next;

    // New bits enter at the MSB, so the first bit sent ends up in entry 0.
    genvar gi;
    generate
        for (gi = 0; gi < TT; gi++) begin : g_shift
            if (gi == TT - 1) begin : g_top
                assign w_tt_next[gi] = shift_bit;
            end else begin : g_mid
                assign w_tt_next[gi] = r_tt[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tt <= '0;
        end else if (shift_en) begin
            r_tt <= w_tt_next;
        end
    end

    assign rd_bit_a = r_tt[rd_addr_a];
    assign rd_bit_b = r_tt[rd_addr_b];

endmodule

// File: rtl/lut_sweep_eval.sv
// N_IN-input boolean function from a serially loaded truth table, with a
// registered live output and an exhaustive sweep that counts true entries.
module lut_sweep_eval
    import lut_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_e,
    input  logic            sweep_start,
    output logic            busy,
    output logic [N_IN-1:0] sweep_vec,
    output logic            done,
    output logic [N_IN:0]   ones_count
);

    state_t          r_state;
    state_t          w_state_next;
    logic [N_IN-1:0] r_sweep_vec;
    logic [N_IN:0]   r_ones_count;
    logic            r_out_e;
    logic            w_live_bit;
    logic            w_sweep_bit;
    logic            w_start;
    logic            w_load_en;
    logic            w_last;

    // A sweep request beats a simultaneous cfg bit, which is dropped.
    assign w_start   = (r_state == IDLE) && sweep_start;
    assign w_load_en = (r_state == IDLE) && cfg_valid && !sweep_start;
    assign w_last    = &r_sweep_vec;

    tt_shift_reg #(
        .N_IN(N_IN)
    ) u_tt (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (w_load_en),
        .shift_bit (cfg_bit),
        .rd_addr_a (in_vec),
        .rd_addr_b (r_sweep_vec),
        .rd_bit_a  (w_live_bit),
        .rd_bit_b  (w_sweep_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (sweep_start) w_state_next = SWEEP;
            SWEEP:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == SWEEP);
        done      = (r_state == DONE);
        cfg_ready = rst_n && (r_state == IDLE);
    end

    // The counter is one bit wider than the index so a full table never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sweep_vec  <= '0;
            r_ones_count <= '0;
            r_out_e      <= 1'b0;
        end else begin
            r_out_e <= w_live_bit;
            if (w_start) begin
                r_sweep_vec  <= '0;
                r_ones_count <= '0;
            end else if (r_state == SWEEP) begin
                r_ones_count <= r_ones_count + {{N_IN{1'b0}}, w_sweep_bit};
                if (!w_last) begin
                    r_sweep_vec <= r_sweep_vec + 1'b1;
                end
            end
        end
    end

    assign out_e      = r_out_e;
    assign sweep_vec  = r_sweep_vec;
    assign ones_count = r_ones_count;

endmodule
